// File: rtl/pulse_rate_counter_if.sv
// Pulse-rate measurement port bundle: raw pulse input toward the counter,
// latched window count and status back to the consumer.
interface pulse_rate_counter_if;
  logic       pulse_in;
  logic [3:0] data;
  logic       valid;
  logic       ovf;

  // Consumer / stimulus side
  modport master (output pulse_in, input data, input valid, input ovf);
  // Counter side
  modport slave  (input pulse_in, output data, output valid, output ovf);
endinterface

// File: rtl/pulse_rate_counter.sv
// Pulse rate counter: synchronizes and debounces an asynchronous pulse input,
// counts accepted rising edges over a free-running 2^N-cycle gate window and
// latches a saturating 4-bit count plus overflow flag at each window end.
//
// Debounce FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_LOW  | stable low level accepted
//   ST_RISE | input went high, qualifying for DB cycles (edge on accept)
//   ST_HIGH | stable high level accepted
//   ST_FALL | input went low, qualifying for DB cycles (no edge)
module pulse_rate_counter #(
  parameter int N  = 22,
  parameter int DB = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  pulse_rate_counter_if.slave  bus
);

  localparam logic [7:0] DB_CNT = 8'(DB);

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } db_state_t;

  logic            s1;
  logic            s;
  db_state_t       state;
  db_state_t       state_nxt;
  logic [7:0]      db_cnt;
  logic [7:0]      db_cnt_nxt;
  logic            edge_pulse;
  logic [N-1:0]    gate;
  logic            tc;
  logic [3:0]      acc;
  logic            ovf_acc;
  logic            acc_inc;
  logic            acc_sat_hit;
  logic [3:0]      data_q;
  logic            valid_q;
  logic            ovf_q;

  // Two-flop synchronizer for the asynchronous pulse pin
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= bus.pulse_in;
      s  <= s1;
    end
  end

  // Debounce FSM state and qualification counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_LOW;
      db_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Debounce FSM next-state: a new level must persist DB cycles past entry
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    case (state)
      ST_LOW: begin
        if (s) begin
          state_nxt  = ST_RISE;
          db_cnt_nxt = 8'd1;
        end
      end
      ST_RISE: begin
        if (!s)                    state_nxt  = ST_LOW;
        else if (db_cnt == DB_CNT) state_nxt  = ST_HIGH;
        else                       db_cnt_nxt = db_cnt + 8'd1;
      end
      ST_HIGH: begin
        if (!s) begin
          state_nxt  = ST_FALL;
          db_cnt_nxt = 8'd1;
        end
      end
      ST_FALL: begin
        if (s)                     state_nxt  = ST_HIGH;
        else if (db_cnt == DB_CNT) state_nxt  = ST_LOW;
        else                       db_cnt_nxt = db_cnt + 8'd1;
      end
      default: begin
        state_nxt  = ST_LOW;
        db_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Debounce FSM output: one-cycle edge when a rising level is accepted
  always_comb begin
    edge_pulse = 1'b0;
    if (state == ST_RISE && s && db_cnt == DB_CNT) edge_pulse = 1'b1;
  end

  // Free-running gate counter; window boundaries depend on nothing else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) gate <= '0;
    else       gate <= gate + 1'b1;
  end

  assign tc          = &gate;
  assign acc_inc     = edge_pulse && (acc != 4'hF);
  assign acc_sat_hit = edge_pulse && (acc == 4'hF);

  // Accumulate edges; at tc the current cycle's edge still joins the closing window
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc     <= 4'd0;
      ovf_acc <= 1'b0;
      data_q  <= 4'd0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (tc) begin
      data_q  <= acc + {3'b000, acc_inc};
      ovf_q   <= ovf_acc | acc_sat_hit;
      valid_q <= 1'b1;
      acc     <= 4'd0;
      ovf_acc <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (acc_inc)     acc     <= acc + 4'd1;
      if (acc_sat_hit) ovf_acc <= 1'b1;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: doc/pulse_rate_counter.md
# pulse_rate_counter

Measures the rate of an external pulse stream by counting debounced rising edges on an asynchronous input pin over a fixed gate window of 2^N clock cycles. At the end of each window it latches the count into a 4-bit value and strobes `valid`. It is the receiving end of the prescaled pulse/LED counter outputs: it reads back a pulse train such as a prescaler output, a wheel encoder or a bumper switch, and produces a 4-bit value for the robot control logic or LEDs.

## Interface
- `N`, 22: gate window exponent. Window length is 2^N clk cycles. Legal range 4..30.
- `DB`, 4: debounce length in clk cycles. The synchronized input must hold a new level this long before it is accepted. Legal range 1..255.
- `clk`  in  1  system clock; the design has one clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `pulse_in`  in  1  raw asynchronous pulse input.
- `data`  out  4  edge count of the last completed window, saturating at 15.
- `valid`  out  1  one-cycle strobe when `data` updates.
- `ovf`  out  1  set when the last completed window had more than 15 edges.

## Operation
**Synchronizer**
- Two flip-flops: `pulse_in` → `s1` → `s`. Both reset to 0.

**Debounce FSM**
- States: LOW, RISE, HIGH, FALL. Counter `db_cnt` is 8 bits. Reset state is LOW with `db_cnt`=0.
- LOW: if `s`=1, go to RISE and set `db_cnt`=1.
- RISE:
  - `s`=0: return to LOW.
  - else if `db_cnt`==DB: go to HIGH and assert internal `edge` for that cycle.
  - else: `db_cnt`++.
- HIGH: if `s`=0, go to FALL and set `db_cnt`=1.
- FALL: mirrors RISE with levels inverted. It returns to HIGH on `s`=1, goes to LOW on `db_cnt`==DB, and never asserts `edge`.

**Gate counter**
- `gate` is an N-bit free-running up-counter. It resets to 0 and wraps from 2^N−1 to 0.
- Terminal cycle `tc` is the cycle where `gate`==2^N−1.

**Accumulator**
- `acc` is 4 bits and `ovf_acc` is 1 bit; both reset to 0.
- On `edge`: if `acc`<15 then `acc`++; else `ovf_acc`<=1.
- On `tc`:
  - `data` <= `acc` plus that cycle's `edge` increment, saturating at 15.
  - `ovf` <= `ovf_acc` OR (`edge` AND `acc`==15).
  - `valid` <= 1.
  - `acc` <= 0 and `ovf_acc` <= 0.
- An edge in the `tc` cycle belongs to the closing window, never the new one.

**Outputs**
- `data` and `ovf` hold their values for the whole following window.
- `valid` is 1 for exactly one cycle per window.

**Reset**
- Asserting `rstn` at any point immediately clears all of the following. No partial window is reported.
  - sync FFs, FSM, `db_cnt`, `gate`, `acc`, `ovf_acc`
  - outputs `data`=0, `valid`=0, `ovf`=0

## Timing
- Edge latency: if `pulse_in` is first sampled high at edge k and stays high, `acc` increments at edge k+2+DB.
- A high or low level shorter than DB+1 cycles at `s` is rejected.
- Minimum countable pulse period is 2·(DB+1) cycles.
- After reset release, the first `valid` rises on the clock edge that captures `tc`. That is the 2^N-th rising edge after release, counting the first edge as 1.
- Subsequent `valid` strobes come every 2^N cycles.
- `data`, `ovf` and `valid` are all registered and change together on the same edge.
- Window boundaries are always defined by `gate` alone. Input activity never shifts them.

## Test plan
All scenarios use N=8 (256-cycle window) and DB=2.
- **Reset:** hold `rstn`=0 for 5 cycles with `pulse_in` toggling → `data`=0, `valid`=0, `ovf`=0. After release, no `valid` before the 256th edge; then `valid`=1 for one cycle with `data`=0.
- **Clean pulses:** 5 pulses (10 high / 10 low) inside one window → at window end `data`=5, `ovf`=0, `valid` high for exactly 1 cycle. `data` stays 5 for the next 256 cycles.
- **Glitch rejection:** 8 one-cycle and 8 two-cycle high glitches spaced 10 cycles apart → `data`=0. Then 3 pulses 4 cycles high → `data`=3.
- **Saturation and recovery:** 20 pulses (5 high / 5 low) in one window → `data`=15, `ovf`=1. Next window with 3 pulses → `data`=3, `ovf`=0.
- **Boundary edge:** timed so that `edge` coincides with `tc` after 6 earlier edges → closing window reports `data`=7. The next window starts at 0.
- **Reset mid-window:** 4 edges, then `rstn` pulsed low for 1 cycle at `gate`=100 → outputs 0. The next `valid` comes 256 cycles after release with `data` counting only post-reset edges.
